rcc_rdy_irq_ctrl: RTL and testbench

Interrupt flag controller for the RCC. It consumes the synchronized oscillator/PLL ready signals and clock-security-system (CSS) fail signals from the port signal synchronizer, and detects rising edges on them. It sets sticky interrupt flags gated by per-source enables, and drives the RCC global interrupt plus the CSS interrupts toward the interrupt controller. Register-file writes (enable, clear) arrive as single-cycle strobes from the RCC register block.

---
 rtl/rcc_pkg.sv | 23 ++
 rtl/rcc_rdy_irq_ctrl_if.sv | 20 ++
 rtl/rcc_rdy_deglitch.sv | 28 ++
 rtl/rcc_rdy_irq_ctrl.sv | 92 +++++++++
 tb/tb_rcc_rdy_irq_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rcc_pkg.sv
// rcc_pkg: shared constants for the RCC ready/CSS interrupt controller.
//   RCC_IRQ_SRC_NUM  : number of interrupt sources (flag register width)
//   RCC_RDY_NUM      : number of ready sources that may be deglitched (bits 0..8)
//   RCC_IRQ_*        : bit index of each source in cier/cifr/cicr
//   RCC_DEGLITCH_CW  : width of the per-source deglitch counter
package rcc_pkg;
  localparam int RCC_IRQ_SRC_NUM = 11;
  localparam int RCC_RDY_NUM     = 9;
  localparam int RCC_IER_W       = 10;
  localparam int RCC_DEGLITCH_CW = 4;

  localparam int RCC_IRQ_LSI    = 0;
  localparam int RCC_IRQ_LSE    = 1;
  localparam int RCC_IRQ_HSI    = 2;
  localparam int RCC_IRQ_HSE    = 3;
  localparam int RCC_IRQ_CSI    = 4;
  localparam int RCC_IRQ_HSI48  = 5;
  localparam int RCC_IRQ_PLL1   = 6;
  localparam int RCC_IRQ_PLL2   = 7;
  localparam int RCC_IRQ_PLL3   = 8;
  localparam int RCC_IRQ_LSECSS = 9;
  localparam int RCC_IRQ_HSECSS = 10;
endpackage

// File: rtl/rcc_rdy_irq_ctrl_if.sv
// rcc_rdy_irq_ctrl_if: register-block side of the interrupt controller.
//   cier_we/cier_wdata : enable register write strobe + data
//   cicr_we/cicr_wdata : write-1-to-clear strobe + data
//   cier/cifr          : enable and flag register read-back
// slave  = interrupt controller, master = RCC register block.
interface rcc_rdy_irq_ctrl_if;
  import rcc_pkg::*;

  logic                       cier_we;
  logic [RCC_IER_W-1:0]       cier_wdata;
  logic                       cicr_we;
  logic [RCC_IRQ_SRC_NUM-1:0] cicr_wdata;
  logic [RCC_IER_W-1:0]       cier;
  logic [RCC_IRQ_SRC_NUM-1:0] cifr;

  modport slave  (input cier_we, cier_wdata, cicr_we, cicr_wdata,
                  output cier, cifr);
  modport master (output cier_we, cier_wdata, cicr_we, cicr_wdata,
                  input cier, cifr);
endinterface

// File: rtl/rcc_rdy_deglitch.sv
// rcc_rdy_deglitch: one-bit ready filter.
//   clk, rst : clock, synchronous active-high reset
//   din      : synchronized ready level
//   lvl      : recognised level; high only after din has been high for
//              CYC consecutive samples, drops the same cycle din drops.
module rcc_rdy_deglitch
  import rcc_pkg::*;
#(
  parameter int CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl
);
  localparam logic [RCC_DEGLITCH_CW-1:0] THR = RCC_DEGLITCH_CW'(CYC - 1);

  logic [RCC_DEGLITCH_CW-1:0] cnt;

  // Saturates at THR so a long high level never wraps back to "not ready".
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (!din)       cnt <= '0;
    else if (cnt != THR) cnt <= cnt + 1'b1;
  end

  assign lvl = din & (cnt == THR);
endmodule

// File: rtl/rcc_rdy_irq_ctrl.sv
// rcc_rdy_irq_ctrl: RCC ready / CSS interrupt flag controller.
//   rcc_rcc_hclk, rcc_rcc_sync_rst : clock, synchronous active-high reset
//   sync_*_rdy, sync_*css_fail     : synchronized source levels (hclk domain)
//   regs                           : register-block port (cier/cicr writes,
//                                    cier/cifr read-back)
//   rcc_it, rcc_lsecss_it,
//   rcc_hsecss_nmi                 : registered interrupt requests
// Optional feature: define RCC_RDY_DEGLITCH_EN to filter ready sources 0..8
// through DEGLITCH_CYC-cycle counters. CSS sources are never filtered.
module rcc_rdy_irq_ctrl
  import rcc_pkg::*;
#(
  parameter int DEGLITCH_CYC = 4
) (
  input  logic                 rcc_rcc_hclk,
  input  logic                 rcc_rcc_sync_rst,
  input  logic                 sync_lsi_rdy,
  input  logic                 sync_lse_rdy,
  input  logic                 sync_hsi_rdy,
  input  logic                 sync_hse_rdy,
  input  logic                 sync_csi_rdy,
  input  logic                 sync_hsi48_rdy,
  input  logic                 sync_pll1_rdy,
  input  logic                 sync_pll2_rdy,
  input  logic                 sync_pll3_rdy,
  input  logic                 sync_lsecss_fail,
  input  logic                 sync_hsecss_fail,
  rcc_rdy_irq_ctrl_if.slave    regs,
  output logic                 rcc_it,
  output logic                 rcc_lsecss_it,
  output logic                 rcc_hsecss_nmi
);
  if (DEGLITCH_CYC < 2 || DEGLITCH_CYC > 15) begin : g_bad_cfg
    $error("rcc_rdy_irq_ctrl: DEGLITCH_CYC must be in 2..15");
  end

  logic [RCC_IRQ_SRC_NUM-1:0] src, lvl, prev_q, rise, set, clr, cifr_q, cifr_d;
  logic [RCC_IER_W-1:0]       cier_q;

  assign src = {sync_hsecss_fail, sync_lsecss_fail, sync_pll3_rdy,
                sync_pll2_rdy, sync_pll1_rdy, sync_hsi48_rdy, sync_csi_rdy,
                sync_hse_rdy, sync_hsi_rdy, sync_lse_rdy, sync_lsi_rdy};

  // CSS fails go straight to edge detection in every build.
  assign lvl[RCC_IRQ_HSECSS:RCC_IRQ_LSECSS] = src[RCC_IRQ_HSECSS:RCC_IRQ_LSECSS];

`ifdef RCC_RDY_DEGLITCH_EN
  for (genvar i = 0; i < RCC_RDY_NUM; i++) begin : g_dg
    rcc_rdy_deglitch #(.CYC(DEGLITCH_CYC)) u_dg (
      .clk (rcc_rcc_hclk),
      .rst (rcc_rcc_sync_rst),
      .din (src[i]),
      .lvl (lvl[i])
    );
  end
`else
  assign lvl[RCC_RDY_NUM-1:0] = src[RCC_RDY_NUM-1:0];
`endif

  // prev resets to 0, so a source high at reset exit gives one rise.
  assign rise = lvl & ~prev_q;

  // hsecss is non-maskable; everything else uses the registered enable,
  // so a cier write only affects rises sampled on the following edges.
  assign set = {rise[RCC_IRQ_HSECSS], rise[RCC_IER_W-1:0] & cier_q};
  assign clr = regs.cicr_we ? regs.cicr_wdata : '0;

  // Set is ORed after the clear so a same-cycle rise wins.
  assign cifr_d = (cifr_q & ~clr) | set;

  always_ff @(posedge rcc_rcc_hclk) begin
    if (rcc_rcc_sync_rst) begin
      prev_q         <= '0;
      cier_q         <= '0;
      cifr_q         <= '0;
      rcc_it         <= 1'b0;
      rcc_lsecss_it  <= 1'b0;
      rcc_hsecss_nmi <= 1'b0;
    end else begin
      prev_q         <= lvl;
      cifr_q         <= cifr_d;
      if (regs.cier_we) cier_q <= regs.cier_wdata;
      // Outputs track the registered flags, one cycle behind cifr.
      rcc_it         <= |(cifr_q[RCC_IER_W-1:0] & cier_q);
      rcc_lsecss_it  <= cifr_q[RCC_IRQ_LSECSS] & cier_q[RCC_IRQ_LSECSS];
      rcc_hsecss_nmi <= cifr_q[RCC_IRQ_HSECSS];
    end
  end

  assign regs.cier = cier_q;
  assign regs.cifr = cifr_q;
endmodule

// File: tb/tb_rcc_rdy_irq_ctrl.sv
// tb_rcc_rdy_irq_ctrl: directed checks of flag set/clear, masking, NMI,
// reset behaviour and (when RCC_RDY_DEGLITCH_EN is defined) the filter.
module tb_rcc_rdy_irq_ctrl;
  localparam int DEG = 4;
`ifdef RCC_RDY_DEGLITCH_EN
  localparam int LAT = DEG - 1;
`else
  localparam int LAT = 0;
`endif

  logic clk, rst;
  logic [10:0] src;
  logic rcc_it, rcc_lsecss_it, rcc_hsecss_nmi;
  int n_tests = 0;
  int n_fail  = 0;

  rcc_rdy_irq_ctrl_if rif();

  rcc_rdy_irq_ctrl #(.DEGLITCH_CYC(DEG)) dut (
    .rcc_rcc_hclk     (clk),
    .rcc_rcc_sync_rst (rst),
    .sync_lsi_rdy     (src[0]),
    .sync_lse_rdy     (src[1]),
    .sync_hsi_rdy     (src[2]),
    .sync_hse_rdy     (src[3]),
    .sync_csi_rdy     (src[4]),
    .sync_hsi48_rdy   (src[5]),
    .sync_pll1_rdy    (src[6]),
    .sync_pll2_rdy    (src[7]),
    .sync_pll3_rdy    (src[8]),
    .sync_lsecss_fail (src[9]),
    .sync_hsecss_fail (src[10]),
    .regs             (rif),
    .rcc_it           (rcc_it),
    .rcc_lsecss_it    (rcc_lsecss_it),
    .rcc_hsecss_nmi   (rcc_hsecss_nmi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs set after tick() are sampled at the next posedge; checks after
  // tick() see the state that edge produced.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_cier(input logic [9:0] v);
    rif.cier_we = 1'b1; rif.cier_wdata = v;
    tick();
    rif.cier_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0;
    rif.cier_we = 1'b0; rif.cier_wdata = '0;
    rif.cicr_we = 1'b0; rif.cicr_wdata = '0;
    tick(2);
    chk("rst_cier", 32'(rif.cier), 32'h0);
    chk("rst_cifr", 32'(rif.cifr), 32'h0);
    chk("rst_irqs", {29'd0, rcc_it, rcc_lsecss_it, rcc_hsecss_nmi}, 32'h0);
    rst = 1'b0;

    // Basic set, clear and interrupt
    wr_cier(10'h3FF);
    chk("cier_wr", 32'(rif.cier), 32'h3FF);
    tick(5);
    src[3] = 1'b1;
    tick(LAT);
    chk("hse_pre", 32'(rif.cifr), 32'h0);
    tick();
    chk("hse_set", 32'(rif.cifr), 32'h008);
    chk("hse_it_lag", 32'(rcc_it), 32'h0);
    tick();
    chk("hse_it", 32'(rcc_it), 32'h1);
    rif.cicr_we = 1'b1; rif.cicr_wdata = 11'h008;
    tick();
    rif.cicr_we = 1'b0;
    chk("hse_clr", 32'(rif.cifr), 32'h0);
    chk("hse_it_hold", 32'(rcc_it), 32'h1);
    tick();
    chk("hse_it_off", 32'(rcc_it), 32'h0);

    // Masked source and NMI
    do_reset();
    src[6] = 1'b1;
    tick(LAT + 3);
    chk("pll1_mask", 32'(rif.cifr), 32'h0);
    chk("pll1_it", 32'(rcc_it), 32'h0);
    src[10] = 1'b1;
    tick();
    chk("hsecss_set", 32'(rif.cifr), 32'h400);
    tick();
    chk("hsecss_nmi", 32'(rcc_hsecss_nmi), 32'h1);
    chk("hsecss_noit", 32'(rcc_it), 32'h0);

    // Set beats clear, falling edge is ignored, LSE CSS interrupt
    do_reset();
    wr_cier(10'h202);
    src[1] = 1'b1;
    tick(LAT);
    rif.cicr_we = 1'b1; rif.cicr_wdata = 11'h002;
    tick();
    rif.cicr_we = 1'b0;
    chk("set_wins", 32'(rif.cifr), 32'h002);
    src[1] = 1'b0;
    tick(2);
    chk("fall_noeff", 32'(rif.cifr), 32'h002);
    src[9] = 1'b1;
    tick();
    chk("lsecss_set", 32'(rif.cifr), 32'h202);
    tick();
    chk("lsecss_it", {30'd0, rcc_lsecss_it, rcc_it}, 32'h3);

    // Ready at reset exit: rise is consumed before the enable lands,
    // unless the filter delays it past the enable write.
    rst = 1'b1; src = 11'h004;
    tick(2);
    rst = 1'b0;
    wr_cier(10'h004);
    tick(5);
    chk("rst_exit", 32'(rif.cifr), (LAT > 0) ? 32'h004 : 32'h0);

    // Reset mid-operation with every flag set
    wr_cier(10'h3FF);
    src = '0;
    tick(2);
    src = 11'h7FF;
    tick(LAT + 1);
    chk("all_set", 32'(rif.cifr), 32'h7FF);
    tick();
    chk("all_irq", {29'd0, rcc_it, rcc_lsecss_it, rcc_hsecss_nmi}, 32'h7);
    rst = 1'b1;
    tick();
    chk("mid_rst_cifr", 32'(rif.cifr), 32'h0);
    chk("mid_rst_cier", 32'(rif.cier), 32'h0);
    chk("mid_rst_irq", {29'd0, rcc_it, rcc_lsecss_it, rcc_hsecss_nmi}, 32'h0);
    src = '0;
    tick();
    rst = 1'b0;

    // Flag survives enable clear
    do_reset();
    wr_cier(10'h040);
    src[6] = 1'b1;
    tick(LAT + 2);
    chk("pll1_set", 32'(rif.cifr), 32'h040);
    chk("pll1_it", 32'(rcc_it), 32'h1);
    wr_cier(10'h000);
    chk("pll1_keep", 32'(rif.cifr), 32'h040);
    chk("pll1_it_hold", 32'(rcc_it), 32'h1);
    tick();
    chk("pll1_it_off", 32'(rcc_it), 32'h0);
    chk("pll1_keep2", 32'(rif.cifr), 32'h040);

`ifdef RCC_RDY_DEGLITCH_EN
    // Deglitch filter
    do_reset();
    wr_cier(10'h3FF);
    src[4] = 1'b1;
    tick(3);
    src[4] = 1'b0;
    tick(3);
    chk("csi_glitch", 32'(rif.cifr), 32'h0);
    src[4] = 1'b1;
    tick(3);
    chk("csi_wait", 32'(rif.cifr), 32'h0);
    tick();
    chk("csi_set", 32'(rif.cifr), 32'h010);
    src[9] = 1'b1;
    tick();
    src[9] = 1'b0;
    chk("lsecss_bypass", 32'(rif.cifr), 32'h210);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
